// File: rtl/ex_cond_stage_pkg.sv
// Shared types and constants for the dual-lane EX condition stage.
package ex_cond_stage_pkg;

  localparam int D_WIDTH = 32;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // One lane's worth of EX/MEM register contents.
  typedef struct packed {
    logic               reg_write;
    logic               memto_reg;
    logic               mem_write;
    logic               pcsrc;
    logic [3:0]         rd;
    logic [D_WIDTH-1:0] alu_result;
    logic [D_WIDTH-1:0] write_data;
  } mem_lane_t;

endpackage

// File: rtl/ex_cond_stage_if.sv
// ID/EX-to-EX/MEM signal bundle; the stage itself uses the slave modport.
interface ex_cond_stage_if;
  import ex_cond_stage_pkg::*;

  logic               stall_m, flush_m;
  logic               pcsrc1_e, pcsrc2_e, branch1_e, branch2_e;
  logic               reg_write1_e, reg_write2_e, memto_reg1_e, memto_reg2_e;
  logic               mem_write1_e, mem_write2_e, flag_write1_e, flag_write2_e;
  logic [3:0]         cond1_e, cond2_e, rd1_e, rd2_e, alu_flags1, alu_flags2;
  logic [D_WIDTH-1:0] alu_result1, alu_result2, write_data1, write_data2;

  logic [3:0]         flags;
  logic               cond_ex1, cond_ex2, pcsrc_taken, taken_lane;
  logic               reg_write1_m, reg_write2_m, memto_reg1_m, memto_reg2_m;
  logic               mem_write1_m, mem_write2_m, pcsrc1_m, pcsrc2_m;
  logic [3:0]         rd1_m, rd2_m;
  logic [D_WIDTH-1:0] alu_result1_m, alu_result2_m, write_data1_m, write_data2_m;

  modport slave (
    input  stall_m, flush_m, pcsrc1_e, pcsrc2_e, branch1_e, branch2_e,
           reg_write1_e, reg_write2_e, memto_reg1_e, memto_reg2_e,
           mem_write1_e, mem_write2_e, flag_write1_e, flag_write2_e,
           cond1_e, cond2_e, rd1_e, rd2_e, alu_flags1, alu_flags2,
           alu_result1, alu_result2, write_data1, write_data2,
    output flags, cond_ex1, cond_ex2, pcsrc_taken, taken_lane,
           reg_write1_m, reg_write2_m, memto_reg1_m, memto_reg2_m,
           mem_write1_m, mem_write2_m, pcsrc1_m, pcsrc2_m, rd1_m, rd2_m,
           alu_result1_m, alu_result2_m, write_data1_m, write_data2_m
  );

  modport master (
    output stall_m, flush_m, pcsrc1_e, pcsrc2_e, branch1_e, branch2_e,
           reg_write1_e, reg_write2_e, memto_reg1_e, memto_reg2_e,
           mem_write1_e, mem_write2_e, flag_write1_e, flag_write2_e,
           cond1_e, cond2_e, rd1_e, rd2_e, alu_flags1, alu_flags2,
           alu_result1, alu_result2, write_data1, write_data2,
    input  flags, cond_ex1, cond_ex2, pcsrc_taken, taken_lane,
           reg_write1_m, reg_write2_m, memto_reg1_m, memto_reg2_m,
           mem_write1_m, mem_write2_m, pcsrc1_m, pcsrc2_m, rd1_m, rd2_m,
           alu_result1_m, alu_result2_m, write_data1_m, write_data2_m
  );
endinterface

// File: rtl/ex_cond_stage_cond_check.sv
// Combinational condition-code evaluator against an {N,Z,C,V} flag set.
module cond_check
  import ex_cond_stage_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);
  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/ex_cond_stage.sv
// Dual-lane condition evaluation with intra-bundle flag forwarding and
// lane-2 squash, feeding the EX/MEM pipeline register and NZCV flags.
module ex_cond_stage
  import ex_cond_stage_pkg::*;
(
  input logic            clk,
  input logic            rst_n,
  ex_cond_stage_if.slave bus
);
  logic       raw1, raw2, cond_ex1, cond_ex2, taken1, taken2;
  logic [3:0] flags_q, f1, flags_next;
  mem_lane_t  lane1_d, lane2_d, lane1_q, lane2_q;

  cond_check u_check1 (.cond(bus.cond1_e), .flags(flags_q), .pass(raw1));
  // Lane 2 evaluates against lane 1's forwarded flags, so no bubble is needed.
  cond_check u_check2 (.cond(bus.cond2_e), .flags(f1),      .pass(raw2));

  always_comb begin
    cond_ex1   = raw1 & ~bus.flush_m;
    f1         = (bus.flag_write1_e & cond_ex1) ? bus.alu_flags1 : flags_q;
    taken1     = cond_ex1 & (bus.pcsrc1_e | bus.branch1_e);
    cond_ex2   = raw2 & ~taken1 & ~bus.flush_m;
    taken2     = cond_ex2 & (bus.pcsrc2_e | bus.branch2_e);
    flags_next = (bus.flag_write2_e & cond_ex2) ? bus.alu_flags2 : f1;

    lane1_d.reg_write  = bus.reg_write1_e & cond_ex1;
    lane1_d.memto_reg  = bus.memto_reg1_e & ~bus.flush_m;
    lane1_d.mem_write  = bus.mem_write1_e & cond_ex1;
    lane1_d.pcsrc      = bus.pcsrc1_e & cond_ex1;
    lane1_d.rd         = bus.rd1_e;
    lane1_d.alu_result = bus.alu_result1;
    lane1_d.write_data = bus.write_data1;

    lane2_d.reg_write  = bus.reg_write2_e & cond_ex2;
    lane2_d.memto_reg  = bus.memto_reg2_e & ~bus.flush_m;
    lane2_d.mem_write  = bus.mem_write2_e & cond_ex2;
    lane2_d.pcsrc      = bus.pcsrc2_e & cond_ex2;
    lane2_d.rd         = bus.rd2_e;
    lane2_d.alu_result = bus.alu_result2;
    lane2_d.write_data = bus.write_data2;
  end

  // Flush overrides stall for the lane register; flags never move on a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
      lane1_q <= '0;
      lane2_q <= '0;
    end else begin
      if (bus.flush_m || !bus.stall_m) begin
        lane1_q <= lane1_d;
        lane2_q <= lane2_d;
      end
      if (!bus.flush_m && !bus.stall_m) flags_q <= flags_next;
    end
  end

  assign bus.flags         = flags_q;
  assign bus.cond_ex1      = cond_ex1;
  assign bus.cond_ex2      = cond_ex2;
  assign bus.pcsrc_taken   = taken1 | taken2;
  assign bus.taken_lane    = ~taken1;

  assign bus.reg_write1_m  = lane1_q.reg_write;
  assign bus.memto_reg1_m  = lane1_q.memto_reg;
  assign bus.mem_write1_m  = lane1_q.mem_write;
  assign bus.pcsrc1_m      = lane1_q.pcsrc;
  assign bus.rd1_m         = lane1_q.rd;
  assign bus.alu_result1_m = lane1_q.alu_result;
  assign bus.write_data1_m = lane1_q.write_data;

  assign bus.reg_write2_m  = lane2_q.reg_write;
  assign bus.memto_reg2_m  = lane2_q.memto_reg;
  assign bus.mem_write2_m  = lane2_q.mem_write;
  assign bus.pcsrc2_m      = lane2_q.pcsrc;
  assign bus.rd2_m         = lane2_q.rd;
  assign bus.alu_result2_m = lane2_q.alu_result;
  assign bus.write_data2_m = lane2_q.write_data;
endmodule

// File: tb/tb_ex_cond_stage.sv
// Scoreboard bench for ex_cond_stage: directed bundles then random traffic,
// checked against an instruction-order reference model.
module tb_ex_cond_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_cond_stage_if bus ();
  ex_cond_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic stall, flush, pcsrc1, pcsrc2, branch1, branch2;
    logic rw1, rw2, mtr1, mtr2, mw1, mw2, fw1, fw2;
    logic [3:0] cond1, cond2, rd1, rd2, af1, af2;
    logic [31:0] res1, res2, wd1, wd2;
  } in_t;

  typedef struct packed {
    logic rw, mtr, mw, pc;
    logic [3:0] rd;
    logic [31:0] res, wd;
  } lane_t;

  typedef struct packed {
    logic [3:0] flags;
    lane_t l1, l2;
  } ms_t;

  typedef struct packed {
    logic ce1, ce2, tk, ln;
    logic [3:0] cur_flags;
    ms_t nxt;
  } exp_t;

  exp_t exp_q[$];
  ms_t  model = '0;
  int   n_vec = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Architectural meaning of each condition code on {N,Z,C,V}.
  function automatic bit holds(input logic [3:0] code, input logic [3:0] f);
    bit n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (code)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string name, input logic [75:0] act, input logic [75:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Drive one bundle at the falling edge and queue what the DUT must show.
  task automatic apply(input in_t v, input bit rst);
    exp_t e;
    ms_t cur;
    logic [3:0] f;
    bit ce1, ce2, t1, t2;
    @(negedge clk);
    rst_n = !rst;
    bus.stall_m = v.stall;          bus.flush_m = v.flush;
    bus.pcsrc1_e = v.pcsrc1;        bus.pcsrc2_e = v.pcsrc2;
    bus.branch1_e = v.branch1;      bus.branch2_e = v.branch2;
    bus.reg_write1_e = v.rw1;       bus.reg_write2_e = v.rw2;
    bus.memto_reg1_e = v.mtr1;      bus.memto_reg2_e = v.mtr2;
    bus.mem_write1_e = v.mw1;       bus.mem_write2_e = v.mw2;
    bus.flag_write1_e = v.fw1;      bus.flag_write2_e = v.fw2;
    bus.cond1_e = v.cond1;          bus.cond2_e = v.cond2;
    bus.rd1_e = v.rd1;              bus.rd2_e = v.rd2;
    bus.alu_flags1 = v.af1;         bus.alu_flags2 = v.af2;
    bus.alu_result1 = v.res1;       bus.alu_result2 = v.res2;
    bus.write_data1 = v.wd1;        bus.write_data2 = v.wd2;

    cur = rst ? '0 : model;
    // Lane 1 executes first; lane 2 sees its flags and dies if it redirected.
    f   = cur.flags;
    ce1 = !v.flush && holds(v.cond1, f);
    if (ce1 && v.fw1) f = v.af1;
    t1  = ce1 && (v.pcsrc1 || v.branch1);
    ce2 = !v.flush && !t1 && holds(v.cond2, f);
    if (ce2 && v.fw2) f = v.af2;
    t2  = ce2 && (v.pcsrc2 || v.branch2);

    e.ce1 = ce1; e.ce2 = ce2; e.tk = t1 || t2; e.ln = !t1;
    e.cur_flags = cur.flags;
    if (rst) begin
      e.nxt = '0;
    end else if (v.flush) begin
      e.nxt = cur;
      e.nxt.l1 = {4'b0000, v.rd1, v.res1, v.wd1};
      e.nxt.l2 = {4'b0000, v.rd2, v.res2, v.wd2};
    end else if (v.stall) begin
      e.nxt = cur;
    end else begin
      e.nxt.flags = f;
      e.nxt.l1 = {v.rw1 & ce1, v.mtr1, v.mw1 & ce1, v.pcsrc1 & ce1, v.rd1, v.res1, v.wd1};
      e.nxt.l2 = {v.rw2 & ce2, v.mtr2, v.mw2 & ce2, v.pcsrc2 & ce2, v.rd2, v.res2, v.wd2};
    end
    model = e.nxt;
    exp_q.push_back(e);
    n_vec++;
  endtask

  function automatic in_t idle();
    in_t v;
    v = '0;
    v.cond1 = 4'hF;
    v.cond2 = 4'hF;
    return v;
  endfunction

  function automatic in_t rand_in();
    in_t v;
    v = '0;
    v.stall = ($urandom_range(0, 4) == 0);
    v.flush = ($urandom_range(0, 9) == 0);
    v.pcsrc1 = ($urandom_range(0, 5) == 0);   v.pcsrc2 = ($urandom_range(0, 5) == 0);
    v.branch1 = ($urandom_range(0, 5) == 0);  v.branch2 = ($urandom_range(0, 5) == 0);
    v.rw1 = 1'($urandom_range(0, 1));   v.rw2 = 1'($urandom_range(0, 1));
    v.mtr1 = 1'($urandom_range(0, 1));  v.mtr2 = 1'($urandom_range(0, 1));
    v.mw1 = 1'($urandom_range(0, 1));   v.mw2 = 1'($urandom_range(0, 1));
    v.fw1 = 1'($urandom_range(0, 1));   v.fw2 = 1'($urandom_range(0, 1));
    v.cond1 = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 15));
    v.cond2 = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 15));
    v.rd1 = 4'($urandom_range(0, 15));  v.rd2 = 4'($urandom_range(0, 15));
    v.af1 = 4'($urandom_range(0, 15));  v.af2 = 4'($urandom_range(0, 15));
    v.res1 = $urandom;  v.res2 = $urandom;
    v.wd1 = $urandom;   v.wd2 = $urandom;
    return v;
  endfunction

  // Monitor: combinational view mid-cycle, registered view just after the edge.
  initial begin
    exp_t e;
    lane_t a1, a2;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("flags_now", 76'(bus.flags), 76'(e.cur_flags));
        check("comb", 76'({bus.cond_ex1, bus.cond_ex2, bus.pcsrc_taken, bus.pcsrc_taken & bus.taken_lane}),
              76'({e.ce1, e.ce2, e.tk, e.tk & e.ln}));
        @(posedge clk);
        #1;
        a1 = {bus.reg_write1_m, bus.memto_reg1_m, bus.mem_write1_m, bus.pcsrc1_m,
              bus.rd1_m, bus.alu_result1_m, bus.write_data1_m};
        a2 = {bus.reg_write2_m, bus.memto_reg2_m, bus.mem_write2_m, bus.pcsrc2_m,
              bus.rd2_m, bus.alu_result2_m, bus.write_data2_m};
        check("flags_m", 76'(bus.flags), 76'(e.nxt.flags));
        check("lane1_m", a1, e.nxt.l1);
        check("lane2_m", a2, e.nxt.l2);
      end
    end
  end

  initial begin
    in_t v;
    apply(idle(), 1'b1);
    apply(idle(), 1'b1);

    v = idle(); v.cond1 = 4'hE; v.rw1 = 1'b1; v.res1 = 32'h1234; v.rd1 = 4'd3;
    apply(v, 1'b0);

    v = idle(); v.fw1 = 1'b1; v.af1 = 4'b0100; v.cond1 = 4'hE; v.cond2 = 4'h0; v.rw2 = 1'b1;
    apply(v, 1'b0);

    v = idle(); v.branch1 = 1'b1; v.cond1 = 4'hE; v.mw2 = 1'b1; v.cond2 = 4'hE;
    apply(v, 1'b0);

    v = idle(); v.cond1 = 4'h1; v.rw1 = 1'b1; v.fw1 = 1'b1; v.af1 = 4'b1000;
    apply(v, 1'b0);

    for (int i = 0; i < 2; i++) begin
      v = rand_in(); v.stall = 1'b1; v.flush = 1'b0;
      apply(v, 1'b0);
    end
    v = idle(); v.stall = 1'b1; v.flush = 1'b1; v.cond1 = 4'hE; v.rw1 = 1'b1;
    v.mtr1 = 1'b1; v.fw1 = 1'b1; v.af1 = 4'b1111; v.res1 = 32'hCAFE;
    apply(v, 1'b0);

    v = idle(); v.cond1 = 4'hE; v.cond2 = 4'hE; v.fw1 = 1'b1; v.fw2 = 1'b1;
    v.af1 = 4'b0001; v.af2 = 4'b0010;
    apply(v, 1'b0);

    v = idle(); v.rw1 = 1'b1; v.rw2 = 1'b1; v.mw2 = 1'b1;
    apply(v, 1'b0);

    v = rand_in(); v.stall = 1'b1; v.flush = 1'b0;
    apply(v, 1'b0);
    v.stall = 1'b1;
    apply(v, 1'b1);
    v = idle(); v.cond1 = 4'hE; v.rw1 = 1'b1; v.res1 = 32'h55AA; v.rd1 = 4'd9;
    apply(v, 1'b0);

    for (int i = 0; i < 400; i++) begin
      v = rand_in();
      apply(v, ($urandom_range(0, 99) == 0));
    end

    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_cond_stage.md
# ex_cond_stage

Dual-lane execute-stage condition unit and EX/MEM pipeline register for the two-wide pipeline. It consumes the control and data fields leaving the ID/EX register together with both ALU results. It evaluates each lane's 4-bit condition code against the architectural NZCV flags it owns, and gates the side-effecting controls. It also resolves intra-bundle flag forwarding and branch squash, then registers the surviving lane state into the MEM stage.

## Interface
- D_WIDTH, 32 (from `param.v`), datapath width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- i_StallM  in  1  hold EX/MEM register and flags.
- i_FlushM  in  1  kill both EX instructions this cycle.
- i_PCSrc{1,2}E, i_Branch{1,2}E, i_RegWrite{1,2}E, i_MemtoReg{1,2}E, i_MemWrite{1,2}E, i_FlagWrite{1,2}E  in  1 each  lane controls from ID/EX.
- i_Cond{1,2}E  in  4  condition field.
- i_Rd{1,2}E  in  4  destination register.
- i_ALUFlags{1,2}  in  4  ALU {N,Z,C,V}.
- i_ALUResult{1,2}, i_WriteData{1,2}  in  D_WIDTH  ALU result and store data.
- o_Flags  out  4  architectural {N,Z,C,V}, registered.
- o_CondEx{1,2}  out  1  combinational condition pass, after squash.
- o_PCSrcTaken  out  1  combinational: a lane redirects the PC this cycle.
- o_TakenLane  out  1  combinational: 0 = lane 1, 1 = lane 2; valid only with o_PCSrcTaken.
- o_RegWrite{1,2}M, o_MemtoReg{1,2}M, o_MemWrite{1,2}M, o_PCSrc{1,2}M  out  1 each  registered gated controls.
- o_Rd{1,2}M  out  4; o_ALUResult{1,2}M, o_WriteData{1,2}M  out  D_WIDTH  registered data.

## Operation
- Condition decode on {N,Z,C,V}, codes 0000–1101 are EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V, HI C&~Z, LS ~C|Z, GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V).
  - 1110 = always.
  - 1111 = never.
- Lane 1 pass: CondEx1 = check(Cond1E, o_Flags) & ~i_FlushM.
- Forwarded flags: F1 = (i_FlagWrite1E & CondEx1) ? i_ALUFlags1 : o_Flags.
- Lane 1 redirect: Taken1 = CondEx1 & (i_PCSrc1E | i_Branch1E).
- Lane 2 pass: CondEx2 = check(Cond2E, F1) & ~Taken1 & ~i_FlushM. Lane 2 is squashed when lane 1 redirects.
- Lane 2 redirect: Taken2 = CondEx2 & (i_PCSrc2E | i_Branch2E).
- o_PCSrcTaken = Taken1 | Taken2; o_TakenLane = ~Taken1.
- Next flags: (i_FlagWrite2E & CondEx2) ? i_ALUFlags2 : F1.
- Registered controls: RegWrite, MemWrite and PCSrc are ANDed with CondEx of their lane. MemtoReg and data fields pass ungated.

## Timing
- Reset (async): all outputs 0, o_Flags = 4'b0000.
- Latency: one cycle from EX inputs to *M outputs and to o_Flags.
- Stall (i_StallM=1, i_FlushM=0): EX/MEM register and o_Flags hold. Combinational outputs still evaluate.
- Flush (i_FlushM=1): CondEx{1,2}=0, o_PCSrcTaken=0.
  - On the edge, flags hold; *M controls load 0; data fields load normally.
  - Flush wins over a simultaneous stall.
- Lane 1 FlagWrite plus lane 2 conditional in the same bundle: lane 2 sees lane 1's new flags in the same cycle, with no bubble.
- Both lanes write flags: lane 2 value wins.
- Reset asserted mid-stall clears everything immediately. The first edge after release loads normally.

## Structure
- Shared package / `param.v`:
  - D_WIDTH.
  - Condition code constants (COND_EQ … COND_NV).
  - Flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
- One sub-module, `cond_check`: purely combinational, cond[3:0] + flags[3:0] → pass. Instantiated twice, with lane 2 fed F1.

## Test plan
- Reset release, then Cond1E=1110, RegWrite1E=1, ALUResult1=32'h1234, Rd1E=4'd3 → after one edge o_RegWrite1M=1, o_ALUResult1M=32'h1234, o_Rd1M=3.
- Lane 1 CMP: FlagWrite1E=1, ALUFlags1=0100, Cond1E=1110. Lane 2 Cond2E=0000 (EQ), RegWrite2E=1, with o_Flags=0000 → CondEx2=1, o_RegWrite2M=1, o_Flags=0100 next cycle.
- Lane 1 Branch1E=1, Cond1E=1110; lane 2 MemWrite2E=1, Cond2E=1110 → o_PCSrcTaken=1, o_TakenLane=0, CondEx2=0, o_MemWrite2M=0.
- o_Flags=0100; Cond1E=0001 (NE), RegWrite1E=1, FlagWrite1E=1, ALUFlags1=1000 → CondEx1=0, o_RegWrite1M=0, o_Flags stays 0100.
- i_StallM=1 for 2 cycles with new inputs → *M outputs and o_Flags unchanged. Assert i_FlushM with i_StallM → controls 0 after the edge, flags unchanged.
- Both lanes FlagWrite, always-cond, ALUFlags1=0001, ALUFlags2=0010 → o_Flags=0010. Cond 1111 on either lane → CondEx=0.
